// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two read requesters and the memory port.
//   slave  : arbiter side (takes requests and memory responses, drives acks/valids/memory strobe)
//   master : environment side (requesters + memory)
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_ack;
    logic              a_valid;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_ack;
    logic              b_valid;
    logic [DATA_W-1:0] rd_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              owner;
    logic              timeout_err;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, mem_ready, mem_data,
        output a_ack, a_valid, b_ack, b_valid, rd_data, mem_req, mem_addr,
               busy, owner, timeout_err
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, mem_ready, mem_data,
        input  a_ack, a_valid, b_ack, b_valid, rd_data, mem_req, mem_addr,
               busy, owner, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single read-only memory port.
// One read outstanding at a time; reads the memory never completes are aborted
// after TIMEOUT wait cycles with an all-ones error word and a sticky flag.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.slave -- requester A/B handshakes, shared rd_data,
//              memory strobe/address/response, busy/owner/timeout_err status
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;           // 0 = A has priority, 1 = B
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              a_valid_q, a_valid_d;
    logic              b_valid_q, b_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic              grant_b;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            rd_data_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            rd_data_q  <= rd_data_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_valid_d  = 1'b0;
        b_valid_d  = 1'b0;
        rd_data_d  = rd_data_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        err_d      = err_q;
        // B wins when it is the only requester, or when both request and B holds priority
        grant_b    = bus.b_req && (!bus.a_req || ptr_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    mem_addr_d = grant_b ? bus.b_addr : bus.a_addr;
                    owner_d    = grant_b;
                    a_ack_d    = !grant_b;
                    b_ack_d    = grant_b;
                    mem_req_d  = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // mem_ready is checked first so it wins a tie with the timeout
                if (bus.mem_ready) begin
                    rd_data_d = bus.mem_data;
                    a_valid_d = !owner_q;
                    b_valid_d = owner_q;
                    ptr_d     = !owner_q;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rd_data_d = '1;
                    err_d     = 1'b1;
                    a_valid_d = !owner_q;
                    b_valid_d = owner_q;
                    ptr_d     = !owner_q;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.a_ack       = a_ack_q;
    assign bus.b_ack       = b_ack_q;
    assign bus.a_valid     = a_valid_q;
    assign bus.b_valid     = b_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.busy        = busy_q;
    assign bus.owner       = owner_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT = 8). Inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    mem_arbiter #(
        .ADDR_W (12),
        .DATA_W (16),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if ({bus.a_ack, bus.b_ack, bus.a_valid, bus.b_valid, bus.mem_req} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {bus.a_ack, bus.b_ack, bus.a_valid, bus.b_valid, bus.mem_req}); end
        checks++; if ({bus.busy, bus.owner, bus.timeout_err} !== 3'b0) begin errors++; $display("FAIL reset_status: got %b want 000", {bus.busy, bus.owner, bus.timeout_err}); end
        checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", bus.rd_data); end
        checks++; if (bus.mem_addr !== 12'h000) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", bus.mem_addr); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_a();
        bus.a_req = 1'b1; bus.a_addr = 12'h004;
        step();
        checks++; if ({bus.a_ack, bus.mem_req, bus.b_ack} !== 3'b110) begin errors++; $display("FAIL single_ack: got a_ack,mem_req,b_ack=%b want 110", {bus.a_ack, bus.mem_req, bus.b_ack}); end
        checks++; if (bus.mem_addr !== 12'h004) begin errors++; $display("FAIL single_addr: got %h want 004", bus.mem_addr); end
        checks++; if ({bus.owner, bus.busy} !== 2'b01) begin errors++; $display("FAIL single_owner_busy: got %b want 01", {bus.owner, bus.busy}); end
        bus.a_req = 1'b0;
        step();
        checks++; if ({bus.a_ack, bus.mem_req} !== 2'b00) begin errors++; $display("FAIL single_pulse_width: got %b want 00", {bus.a_ack, bus.mem_req}); end
        step();
        step();
        bus.mem_ready = 1'b1; bus.mem_data = 16'h1234;
        step();
        bus.mem_ready = 1'b0;
        checks++; if ({bus.a_valid, bus.b_valid} !== 2'b10) begin errors++; $display("FAIL single_valid: got a_valid,b_valid=%b want 10", {bus.a_valid, bus.b_valid}); end
        checks++; if (bus.rd_data !== 16'h1234) begin errors++; $display("FAIL single_data: got %h want 1234", bus.rd_data); end
        checks++; if ({bus.busy, bus.owner} !== 2'b00) begin errors++; $display("FAIL single_done: busy,owner=%b want 00", {bus.busy, bus.owner}); end
        step();
        checks++; if ({bus.a_valid, bus.rd_data} !== {1'b0, 16'h1234}) begin errors++; $display("FAIL single_hold: a_valid=%b rd_data=%h want 0 1234", bus.a_valid, bus.rd_data); end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1; step(); rst = 1'b0; step();
        bus.a_req = 1'b1; bus.a_addr = 12'h010;
        bus.b_req = 1'b1; bus.b_addr = 12'h020;
        step();
        checks++; if ({bus.a_ack, bus.b_ack, bus.mem_addr} !== {2'b10, 12'h010}) begin errors++; $display("FAIL sim_first_grant: acks=%b addr=%h want 10 010", {bus.a_ack, bus.b_ack}, bus.mem_addr); end
        bus.a_req = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_data = 16'hAAAA;
        step();
        bus.mem_ready = 1'b0;
        checks++; if ({bus.a_valid, bus.rd_data} !== {1'b1, 16'hAAAA}) begin errors++; $display("FAIL sim_min_latency: a_valid=%b rd_data=%h want 1 aaaa", bus.a_valid, bus.rd_data); end
        step();
        checks++; if ({bus.b_ack, bus.mem_req, bus.owner, bus.mem_addr} !== {3'b111, 12'h020}) begin errors++; $display("FAIL sim_second_grant: b_ack,mem_req,owner=%b addr=%h want 111 020", {bus.b_ack, bus.mem_req, bus.owner}, bus.mem_addr); end
        bus.b_req = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_data = 16'h5555;
        step();
        bus.mem_ready = 1'b0;
        checks++; if ({bus.a_valid, bus.b_valid, bus.rd_data} !== {2'b01, 16'h5555}) begin errors++; $display("FAIL sim_b_valid: valids=%b rd_data=%h want 01 5555", {bus.a_valid, bus.b_valid}, bus.rd_data); end
    endtask

    task automatic test_fairness();
        int  k;
        logic got_b;
        bus.a_addr = 12'h100; bus.b_addr = 12'h200;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            k = 0;
            do begin
                step();
                k++;
            end while (!(bus.a_ack || bus.b_ack) && k < 20);
            checks++; if (!(bus.a_ack || bus.b_ack)) begin errors++; $display("FAIL fair_ack_timeout: txn %0d no ack within %0d cycles", i, k); end
            got_b = bus.b_ack;
            checks++; if (got_b !== 1'(i % 2)) begin errors++; $display("FAIL fair_order: txn %0d granted b=%b want %b", i, got_b, 1'(i % 2)); end
            checks++; if (bus.mem_addr !== (got_b ? 12'h200 : 12'h100)) begin errors++; $display("FAIL fair_addr: txn %0d mem_addr=%h", i, bus.mem_addr); end
            if (got_b) bus.b_req = 1'b0; else bus.a_req = 1'b0;
            bus.mem_ready = 1'b1; bus.mem_data = 16'(16'hC000 + i);
            step();
            bus.mem_ready = 1'b0;
            checks++; if ({bus.a_valid, bus.b_valid, bus.rd_data} !== {~1'(i % 2), 1'(i % 2), 16'(16'hC000 + i)}) begin errors++; $display("FAIL fair_valid: txn %0d valids=%b rd_data=%h", i, {bus.a_valid, bus.b_valid}, bus.rd_data); end
            bus.a_req = 1'b1; bus.b_req = 1'b1;
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bus.a_req = 1'b1; bus.a_addr = 12'h030;
        step();
        bus.a_req = 1'b0;
        checks++; if (bus.a_ack !== 1'b1) begin errors++; $display("FAIL to_ack: a_ack=%b want 1", bus.a_ack); end
        for (int i = 0; i < 7; i++) step();
        checks++; if ({bus.a_valid, bus.busy, bus.timeout_err} !== 3'b010) begin errors++; $display("FAIL to_early: a_valid,busy,err=%b want 010", {bus.a_valid, bus.busy, bus.timeout_err}); end
        step();
        checks++; if ({bus.a_valid, bus.busy, bus.timeout_err} !== 3'b101) begin errors++; $display("FAIL to_fire: a_valid,busy,err=%b want 101", {bus.a_valid, bus.busy, bus.timeout_err}); end
        checks++; if (bus.rd_data !== 16'hFFFF) begin errors++; $display("FAIL to_err_word: rd_data=%h want ffff", bus.rd_data); end
        step();
        bus.b_req = 1'b1; bus.b_addr = 12'h040;
        step();
        bus.b_req = 1'b0;
        checks++; if ({bus.b_ack, bus.mem_addr} !== {1'b1, 12'h040}) begin errors++; $display("FAIL to_next_grant: b_ack=%b addr=%h want 1 040", bus.b_ack, bus.mem_addr); end
        bus.mem_ready = 1'b1; bus.mem_data = 16'h0BEE;
        step();
        bus.mem_ready = 1'b0;
        checks++; if ({bus.b_valid, bus.rd_data, bus.timeout_err} !== {1'b1, 16'h0BEE, 1'b1}) begin errors++; $display("FAIL to_sticky: b_valid=%b rd_data=%h err=%b want 1 0bee 1", bus.b_valid, bus.rd_data, bus.timeout_err); end
    endtask

    task automatic test_races();
        rst = 1'b1; step(); rst = 1'b0; step();
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL race_err_cleared: err=%b want 0", bus.timeout_err); end
        bus.mem_ready = 1'b1; bus.mem_data = 16'h7777;
        step();
        bus.mem_ready = 1'b0;
        checks++; if ({bus.a_valid, bus.b_valid, bus.busy, bus.rd_data} !== {3'b000, 16'h0000}) begin errors++; $display("FAIL race_idle_ready: valids,busy=%b rd_data=%h want 000 0000", {bus.a_valid, bus.b_valid, bus.busy}, bus.rd_data); end
        bus.a_req = 1'b1; bus.a_addr = 12'h050;
        step();
        bus.a_req = 1'b0;
        for (int i = 0; i < 7; i++) step();
        bus.mem_ready = 1'b1; bus.mem_data = 16'h4321;
        step();
        bus.mem_ready = 1'b0;
        checks++; if ({bus.a_valid, bus.rd_data, bus.timeout_err} !== {1'b1, 16'h4321, 1'b0}) begin errors++; $display("FAIL race_last_cycle: a_valid=%b rd_data=%h err=%b want 1 4321 0", bus.a_valid, bus.rd_data, bus.timeout_err); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        bus.b_req = 1'b1; bus.b_addr = 12'h060;
        step();
        bus.b_req = 1'b0;
        checks++; if ({bus.b_ack, bus.mem_req} !== 2'b11) begin errors++; $display("FAIL rmw_grant: b_ack,mem_req=%b want 11", {bus.b_ack, bus.mem_req}); end
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.owner, bus.mem_addr, bus.rd_data} !== {2'b00, 12'h000, 16'h0000}) begin errors++; $display("FAIL rmw_async: busy,owner=%b addr=%h rd_data=%h want 00 000 0000", {bus.busy, bus.owner}, bus.mem_addr, bus.rd_data); end
        step();
        rst = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_data = 16'h9999;
        step();
        bus.mem_ready = 1'b0;
        checks++; if ({bus.a_valid, bus.b_valid, bus.rd_data} !== {2'b00, 16'h0000}) begin errors++; $display("FAIL rmw_late_ready: valids=%b rd_data=%h want 00 0000", {bus.a_valid, bus.b_valid}, bus.rd_data); end
        bus.a_req = 1'b1; bus.a_addr = 12'h070;
        bus.b_req = 1'b1; bus.b_addr = 12'h080;
        step();
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        checks++; if ({bus.a_ack, bus.b_ack, bus.mem_addr} !== {2'b10, 12'h070}) begin errors++; $display("FAIL rmw_ptr_a: acks=%b addr=%h want 10 070", {bus.a_ack, bus.b_ack}, bus.mem_addr); end
        bus.mem_ready = 1'b1; bus.mem_data = 16'h2468;
        step();
        bus.mem_ready = 1'b0;
        checks++; if ({bus.a_valid, bus.rd_data} !== {1'b1, 16'h2468}) begin errors++; $display("FAIL rmw_recover: a_valid=%b rd_data=%h want 1 2468", bus.a_valid, bus.rd_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_addr = '0;
        bus.b_req = 1'b0; bus.b_addr = '0;
        bus.mem_ready = 1'b0; bus.mem_data = '0;
        test_reset();
        test_single_a();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_races();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
